stopwatch_ctrl: RTL and testbench

Button-driven sequencer that sits between the board push-buttons and the stopwatch counter. It synchronizes and debounces two buttons, runs the IDLE/RUNNING/STOPPED state machine, and drives the stopwatch's 3-bit control vector as single-cycle command pulses. With lap support compiled in, it also captures lap times from the stopwatch count output.

---
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- push-button front end for the stopwatch counter.
//
// Synchronizes and debounces the start/stop (btn_ss) and lap/reset (btn_lr)
// buttons, runs the IDLE/RUNNING/STOPPED sequencer and drives the counter's
// control vector as one-cycle command pulses. Optional lap capture is
// compiled in with `define STOPWATCH_LAP_EN.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   btn_ss       raw start/stop button (async, active-high)
//   btn_lr       raw lap/reset button  (async, active-high)
//   count_in     current stopwatch count (sampled for lap capture)
//   control      {stop, reset, start}, registered, one-hot or zero
//   running      high while in RUNNING
//   lap_value    last captured lap time
//   lap_valid    one-cycle pulse when lap_value updates
//   lap_count    laps since last reset command, saturating at 15

// Per-button synchronizer + debouncer. press pulses one cycle when the
// debounced level rises.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            deb   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] != deb) begin
                // Level accepted once the counter has reached the limit;
                // the pulse is registered here so it lines up with the flip.
                if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    deb   <= ~deb;
                    cnt   <= '0;
                    press <= ~deb;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_ss,
    input  logic        btn_lr,
    input  logic [31:0] count_in,
    output logic [2:0]  control,
    output logic        running,
    output logic [31:0] lap_value,
    output logic        lap_valid,
    output logic [3:0]  lap_count
);
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_RESET = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;

    // Index 0 = start/stop, index 1 = lap/reset.
    logic [1:0] btns;
    logic [1:0] press;
    assign btns = {btn_lr, btn_ss};

    for (genvar i = 0; i < 2; i++) begin : g_db
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btns[i]),
            .press (press[i])
        );
    end

    state_t state;
    logic   init_done;

`ifdef STOPWATCH_LAP_EN
    logic [31:0] lap_value_r;
    logic        lap_valid_r;
    logic [3:0]  lap_count_r;
    assign lap_value = lap_value_r;
    assign lap_valid = lap_valid_r;
    assign lap_count = lap_count_r;
`else
    logic unused_count;
    assign unused_count = ^count_in;
    assign lap_value = 32'd0;
    assign lap_valid = 1'b0;
    assign lap_count = 4'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            init_done <= 1'b0;
            control   <= 3'b000;
            running   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_value_r <= 32'd0;
            lap_valid_r <= 1'b0;
            lap_count_r <= 4'd0;
`endif
        end else begin
            control <= 3'b000;
`ifdef STOPWATCH_LAP_EN
            lap_valid_r <= 1'b0;
`endif
            if (!init_done) begin
                // First edge out of reset: resync the counter, drop events.
                init_done <= 1'b1;
                control   <= CMD_RESET;
            end else if (press[0]) begin
                // ss wins over a coincident lr.
                case (state)
                    RUNNING: begin
                        state   <= STOPPED;
                        control <= CMD_STOP;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= RUNNING;
                        control <= CMD_START;
                        running <= 1'b1;
                    end
                endcase
            end else if (press[1]) begin
                case (state)
                    RUNNING: begin
`ifdef STOPWATCH_LAP_EN
                        lap_value_r <= count_in;
                        lap_valid_r <= 1'b1;
                        if (lap_count_r != 4'd15)
                            lap_count_r <= lap_count_r + 4'd1;
`endif
                    end
                    default: begin
                        state   <= IDLE;
                        control <= CMD_RESET;
`ifdef STOPWATCH_LAP_EN
                        lap_count_r <= 4'd0;
`endif
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl with DEBOUNCE_CYCLES = 4. Stimulus is
// a list of button presses (mask, high time, low time); a press held at
// least DC+1 cycles yields an event whose effect appears at edge E+DC+3,
// shorter ones yield nothing. The reference model is the command table.
module tb_stopwatch_ctrl;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_lr = 1'b0;
    logic [31:0] count_in = 32'd0;
    logic [2:0]  control;
    logic        running;
    logic [31:0] lap_value;
    logic        lap_valid;
    logic [3:0]  lap_count;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .count_in  (count_in),
        .control   (control),
        .running   (running),
        .lap_value (lap_value),
        .lap_valid (lap_valid),
        .lap_count (lap_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 = idle, 1 = running, 2 = stopped.
    int          m_mode = 0;
    logic [31:0] m_lapv = 0;
    int          m_lapc = 0;

    task automatic model_event(input bit ss, input bit lr,
                               output logic [2:0] ec, output bit lv);
        ec = 3'b000;
        lv = 1'b0;
        if (ss) begin
            if (m_mode == 1) begin m_mode = 2; ec = 3'b100; end
            else             begin m_mode = 1; ec = 3'b001; end
        end else if (lr) begin
            if (m_mode == 1) begin
`ifdef STOPWATCH_LAP_EN
                m_lapv = count_in;
                m_lapc = (m_lapc < 15) ? m_lapc + 1 : 15;
                lv = 1'b1;
`endif
            end else begin
                m_mode = 0;
                ec = 3'b010;
                m_lapc = 0;
            end
        end
    endtask

    task automatic check_cycle(input logic [2:0] ec, input bit lv);
        chk("control", {29'd0, control}, {29'd0, ec});
        chk("running", {31'd0, running}, {31'd0, (m_mode == 1)});
        chk("lap_valid", {31'd0, lap_valid}, {31'd0, lv});
`ifdef STOPWATCH_LAP_EN
        chk("lap_value", lap_value, m_lapv);
        chk("lap_count", {28'd0, lap_count}, m_lapc);
`else
        chk("lap_value", lap_value, 32'd0);
        chk("lap_count", {28'd0, lap_count}, 32'd0);
`endif
    endtask

    // Called #1 after a posedge; edge E is the next posedge.
    task automatic tx(input bit ss, input bit lr, input int len, input int low);
        logic [2:0] ec;
        bit lv;
        btn_ss = ss;
        btn_lr = lr;
        for (int k = 0; k < len + low; k++) begin
            @(posedge clk); #1;
            ec = 3'b000;
            lv = 1'b0;
            if (len >= DC + 1 && k == DC + 3) model_event(ss, lr, ec, lv);
            check_cycle(ec, lv);
            if (k + 1 >= len) begin btn_ss = 1'b0; btn_lr = 1'b0; end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".control"}, {29'd0, control}, 32'd0);
        chk({tag, ".running"}, {31'd0, running}, 32'd0);
        chk({tag, ".lap_value"}, lap_value, 32'd0);
        chk({tag, ".lap_valid"}, {31'd0, lap_valid}, 32'd0);
        chk({tag, ".lap_count"}, {28'd0, lap_count}, 32'd0);
    endtask

    initial begin
        logic [2:0] ec;
        bit lv;
        int m;

        // Reset and init pulse.
        repeat (3) @(posedge clk);
        #1 chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init.control", {29'd0, control}, 32'd2);
        chk("init.running", {31'd0, running}, 32'd0);
        @(posedge clk); #1;
        chk("init.after", {29'd0, control}, 32'd0);

        // Bounce in IDLE: no event.
        tx(1, 0, 3, 6);
        tx(1, 0, 3, 6);
        tx(1, 0, DC, DC + 4);

        // Start / stop / start.
        tx(1, 0, 10, DC + 4);
        tx(1, 0, 10, DC + 4);
        tx(1, 0, 10, DC + 4);

        // Laps in RUNNING, then saturation.
        count_in = 32'd1234;
        tx(0, 1, 10, DC + 4);
        for (int i = 0; i < 16; i++) begin
            count_in = $urandom;
            tx(0, 1, DC + 1 + (i % 3), DC + 4);
        end

        // Stop, then reset: lap_value retained.
        tx(1, 0, 8, DC + 4);
        tx(0, 1, 8, DC + 4);

        // Simultaneous presses in RUNNING: only stop.
        tx(1, 0, 8, DC + 4);
        count_in = 32'hdead_beef;
        tx(1, 1, 8, DC + 4);

        // Random press sequences.
        for (int i = 0; i < 60; i++) begin
            count_in = $urandom;
            m = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0)
                tx(m[0], m[1], $urandom_range(1, DC), $urandom_range(DC + 4, DC + 8));
            else
                tx(m[0], m[1], $urandom_range(DC + 1, DC + 6), $urandom_range(DC + 4, DC + 8));
        end

        // Async reset mid-debounce while running, button held through release.
        if (m_mode != 1) tx(1, 0, 8, DC + 4);
        count_in = 32'd77;
        tx(0, 1, 8, DC + 4);
        btn_ss = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async");
        m_mode = 0; m_lapv = 0; m_lapc = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < DC + 6; k++) begin
            @(posedge clk); #1;
            ec = (k == 0) ? 3'b010 : 3'b000;
            lv = 1'b0;
            if (k == DC + 3) model_event(1, 0, ec, lv);
            check_cycle(ec, lv);
        end
        btn_ss = 1'b0;
        repeat (DC + 4) begin
            @(posedge clk); #1;
            check_cycle(3'b000, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
